// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Registers the winning operands, captures the ALU result and returns it over a valid/ready channel.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CODE_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CODE_W-1:0] req0_alucode,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_br_taken,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CODE_W-1:0] req1_alucode,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_br_taken,
  output logic [CODE_W-1:0] alu_alucode,
  output logic [DATA_W-1:0] alu_rs1,
  output logic [DATA_W-1:0] alu_rs2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_br_taken,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q;
  logic                owner_q;
  logic [CODE_W-1:0]   code_q;
  logic [DATA_W-1:0]   op1_q;
  logic [DATA_W-1:0]   op2_q;
  logic [DATA_W-1:0]   result_q;
  logic                br_q;

  logic                grant_valid;
  logic                grant;
  logic                accept;
  logic                owner_ready;

  // Round-robin: on a tie the requester that did not win last time is granted.
  always_comb begin
    grant_valid = 1'b0;
    grant       = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant       = ~last_grant_q;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant       = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant       = 1'b1;
    end
  end

  assign accept      = (state_q == IDLE) && grant_valid;
  assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (owner_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      code_q       <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      result_q     <= '0;
      br_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q      <= grant;
        last_grant_q <= grant;
        code_q       <= grant ? req1_alucode : req0_alucode;
        op1_q        <= grant ? req1_op1     : req0_op1;
        op2_q        <= grant ? req1_op2     : req0_op2;
      end
      if (state_q == EXEC) begin
        result_q <= alu_result;
        br_q     <= alu_br_taken;
      end
    end
  end

  assign req0_ready    = accept && !grant;
  assign req1_ready    = accept &&  grant;
  assign rsp0_valid    = (state_q == RESP) && !owner_q;
  assign rsp1_valid    = (state_q == RESP) &&  owner_q;
  assign rsp0_result   = result_q;
  assign rsp1_result   = result_q;
  assign rsp0_br_taken = br_q;
  assign rsp1_br_taken = br_q;
  assign alu_alucode   = code_q;
  assign alu_rs1       = op1_q;
  assign alu_rs2       = op2_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: req0 = execute stage, req1 = address/branch helper unit.
- Arbitrates round-robin and registers the winning operands, so the ALU sees stable inputs for one full cycle.
- Captures alu_result/br_taken and returns them to the winning requester over a valid/ready response channel.
- One operation in flight at a time; sits between the requesters and the alu instance.

Parameters:
DATA_W, 32, operand/result width
CODE_W, 6, alucode width (`ALU_* encodings from define.vh)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 accepted this cycle when valid&ready
req0_alucode  in  CODE_W  operation code
req0_op1  in  DATA_W  operand 1
req0_op2  in  DATA_W  operand 2
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 consumes result
rsp0_result  out  DATA_W  captured alu_result
rsp0_br_taken  out  1  captured br_taken
req1_*/rsp1_*  same set and widths as req0_*/rsp0_*, for requester 1
alu_alucode  out  CODE_W  to ALU alucode
alu_rs1  out  DATA_W  to ALU rs1
alu_rs2  out  DATA_W  to ALU rs2
alu_result  in  DATA_W  from ALU
alu_br_taken  in  1  from ALU
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values:
  - state=IDLE, last_grant=1 (req0 wins first tie), owner=0.
  - Latched code/op1/op2 = 0, so alu_* outputs = 0.
  - rsp*_valid=0, rsp*_result=0, rsp*_br_taken=0, busy=0.
- FSM states: IDLE, EXEC, RESP.
- Grant (combinational, IDLE only):
  - Only one valid: that requester is granted.
  - Both valid: grant the requester != last_grant.
  - Neither valid: no grant.
  - reqN_ready = (state==IDLE) & grant==N.
  - Both readies are 0 in EXEC and RESP.
- IDLE:
  - On reqN_valid & reqN_ready: latch alucode/op1/op2, set owner=N, set last_grant=N, go to EXEC.
  - A requester may drop valid before acceptance; grant is re-evaluated every cycle.
- EXEC (exactly one cycle):
  - alu_* driven from latched registers.
  - At the closing edge, capture alu_result→result reg and alu_br_taken→br reg, then go to RESP.
- RESP:
  - rsp[owner]_valid=1; the other rsp*_valid=0.
  - Result/br_taken held stable until rsp[owner]_ready.
  - On ready: clear valid and go to IDLE. A new accept can occur in that same IDLE cycle.
  - If ready is already high on entry, RESP lasts one cycle.
- alu_* outputs always reflect the latched registers; they change only on acceptance.
- rsp*_result/br_taken outputs show the captured registers regardless of valid. Consumers sample only when valid.
- Timing:
  - Accept at edge k, capture at edge k+1, rsp_valid high after edge k+1.
  - Minimum issue interval is 3 cycles (IDLE, EXEC, RESP).
- alucode is passed unmodified; no decode or check. br_taken is returned for every op; for non-branch codes it is whatever the ALU drives.
- Width rules: no arithmetic in this block; all data fields pass at DATA_W.
- Reset mid-operation (EXEC or RESP): the op is discarded, no response is issued, and all registers return to reset values.
- Simultaneous events:
  - A new reqN_valid during EXEC/RESP is ignored and stays pending; it is granted in the next IDLE.
  - rsp_ready while rsp_valid=0 has no effect.

Test Plan:
- Reset then idle: rst pulse mid-cycle (asynchronous) → all outputs 0, busy=0, req0_ready/req1_ready=0 with no valid.
- Single op: req0 `ALU_ADD`, op1=5, op2=7, rsp0_ready=1 → req0_ready=1 at cycle 0; alu_rs1=5, alu_rs2=7 in cycle 1; rsp0_valid=1 with result=12, br_taken=0 in cycle 2; rsp1_valid=0 throughout.
- Tie and fairness: req0 and req1 both held valid (req0 `ALU_SUB` 10,3; req1 `ALU_BEQ` 4,4) → req0 served first (result=7); req1 served next (br_taken=1, result=0); alternation continues for 4 grants.
- Response backpressure: req1 `ALU_XOR` 0xF0F0,0x0FF0 with rsp1_ready=0 for 5 cycles → rsp1_valid stays 1, result holds 0xFF00, req*_ready=0, busy=1; ready high → IDLE next cycle.
- Reset mid-op: rst asserted during EXEC of req0 → no rsp0_valid ever; after release, req1 `ALU_OR` 1,2 → result 3 to rsp1.
- Operand stability: req0 changes op1 after acceptance, during EXEC → alu_rs1 keeps the accepted value and result uses the accepted operands.
